// File: rtl/mem_arbiter2.sv
// Two-port round-robin arbiter and sequencer for a shared 4096x32 memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins).
module mem_arbiter2 #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int QUANTUM = 1
) (
  input  logic              clock,
  input  logic              preset_L,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  logic gnt0, gnt1, any_gnt;
  logic win;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win = 1'b0;
`else
  localparam logic [3:0] QMAX = 4'(QUANTUM);

  logic       owner;
  logic [3:0] run;
  logic       keep;

  // run==0 only after reset: the non-owner (port 0) takes first contention
  assign keep = (run != 4'd0) && (run < QMAX);
  assign win  = keep ? owner : ~owner;

  always_ff @(posedge clock or negedge preset_L) begin
    if (!preset_L) begin
      owner <= 1'b1;
      run   <= 4'd0;
    end else if (any_gnt) begin
      if (gnt1 == owner) begin
        run <= (run >= QMAX) ? QMAX : run + 4'd1;
      end else begin
        owner <= gnt1;
        run   <= 4'd1;
      end
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid: begin
        gnt0 = ~win;
        gnt1 = win;
      end
      req0_valid && !req1_valid: gnt0 = 1'b1;
      !req0_valid && req1_valid: gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign req0_ready = gnt0 & preset_L;
  assign req1_ready = gnt1 & preset_L;
  assign any_gnt    = req0_ready | req1_ready;

  logic              stg_valid;
  logic              stg_port;
  logic              stg_we;
  logic [ADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0] stg_wdata;

  always_ff @(posedge clock or negedge preset_L) begin
    if (!preset_L) begin
      stg_valid <= 1'b0;
      stg_port  <= 1'b0;
      stg_we    <= 1'b0;
      stg_addr  <= '0;
      stg_wdata <= '0;
    end else begin
      stg_valid <= any_gnt;
      if (any_gnt) begin
        stg_port  <= req1_ready;
        stg_we    <= req1_ready ? req1_we : req0_we;
        stg_addr  <= req1_ready ? req1_addr : req0_addr;
        stg_wdata <= req1_ready ? req1_wdata : req0_wdata;
      end
    end
  end

  assign busy        = stg_valid;
  assign mem_enable  = stg_valid;
  assign mem_we      = stg_valid & stg_we;
  assign mem_address = stg_valid ? stg_addr : '0;
  assign mem_data_in = stg_valid ? stg_wdata : '0;

  logic rd0, rd1;
  assign rd0 = stg_valid & ~stg_we & ~stg_port;
  assign rd1 = stg_valid & ~stg_we & stg_port;

  always_ff @(posedge clock or negedge preset_L) begin
    if (!preset_L) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rd0;
      rsp1_valid <= rd1;
      if (rd0) rsp0_rdata <= mem_data_out;
      if (rd1) rsp1_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Scoreboard bench for mem_arbiter2: random and directed traffic
// against a behavioural arbitration/memory model.
module tb_mem_arbiter2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int Q  = 3;

  logic          clock = 1'b0;
  logic          preset_L;
  logic          req0_valid, req0_we, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          rsp0_valid;
  logic          req1_valid, req1_we, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          rsp1_valid;
  logic          mem_enable, mem_we, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;

  always #5 clock = ~clock;

  mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .QUANTUM(Q)) dut (
    .clock(clock), .preset_L(preset_L),
    .req0_valid(req0_valid), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_enable(mem_enable), .mem_we(mem_we),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, 20'h0} ^ (32'(a) * 32'h9E3779B1);
  endfunction

  // memory device attached to the DUT
  bit [DW-1:0] dev_mem [4096];
  bit          dev_wr  [4096];
  assign mem_data_out = dev_wr[mem_address] ? dev_mem[mem_address]
                                            : init_val(mem_address);
  always @(posedge clock)
    if (mem_enable && mem_we) begin
      dev_mem[mem_address] <= mem_data_in;
      dev_wr[mem_address]  <= 1'b1;
    end

  // reference model
  typedef struct {
    int          port;
    logic [DW-1:0] data;
    int          due;
  } rsp_t;

  logic [DW-1:0] ref_mem [4096];
  rsp_t          sb [$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  bit            pv [2];
  bit            pwe [2];
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  int            last_port = 1;
  int            streak = 0;
  bit            prev_v = 0;
  bit            prev_we;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    req0_valid = pv[0]; req0_we = pwe[0];
    req0_addr  = pa[0]; req0_wdata = pd[0];
    req1_valid = pv[1]; req1_we = pwe[1];
    req1_addr  = pa[1]; req1_wdata = pd[1];
  endtask

  task automatic model_reset();
    last_port = 1;
    streak    = 0;
    prev_v    = 0;
    sb.delete();
  endtask

  task automatic model_check();
    int g;
    g = -1;
    if (preset_L) begin
      if (pv[0] && pv[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = (streak > 0 && streak < Q) ? last_port : 1 - last_port;
`endif
      end else if (pv[0]) g = 0;
      else if (pv[1]) g = 1;
    end
    chk("ready0", 64'(req0_ready), 64'(g == 0));
    chk("ready1", 64'(req1_ready), 64'(g == 1));
    chk("busy", 64'(busy), 64'(prev_v));
    if (prev_v) begin
      chk("mem_address", 64'(mem_address), 64'(prev_a));
      chk("mem_we", 64'(mem_we), 64'(prev_we));
      if (prev_we) chk("mem_data_in", 64'(mem_data_in), 64'(prev_d));
    end
    prev_v = (g >= 0);
    if (g >= 0) begin
      if (g == last_port) streak++;
      else begin
        last_port = g;
        streak    = 1;
      end
      prev_we = pwe[g];
      prev_a  = pa[g];
      prev_d  = pd[g];
      if (pwe[g]) ref_mem[pa[g]] = pd[g];
      else sb.push_back('{g, ref_mem[pa[g]], cyc + 2});
      pv[g] = 0;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clock);
    model_check();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int p, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[p] = 1; pwe[p] = we; pa[p] = a; pd[p] = d;
  endtask

  // response monitor
  always @(negedge clock) begin
    rsp_t e;
    if (preset_L) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 64'(0), 64'(e.due));
      end
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_port", {62'd0, rsp1_valid, rsp0_valid},
              (e.port == 1) ? 64'd2 : 64'd1);
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          chk("rsp_rdata", 64'(e.port == 1 ? rsp1_rdata : rsp0_rdata),
              64'(e.data));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(AW'(i));
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pwe[i] = 0; pa[i] = '0; pd[i] = '0;
    end
    preset_L = 1'b1;
    drive();
    #1 preset_L = 1'b0;
    set_req(0, 0, 12'h001, '0);
    set_req(1, 0, 12'h002, '0);
    drive();
    #12;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_mem_enable", 64'(mem_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    chk("rst_rdata", {rsp1_rdata, rsp0_rdata}, 64'd0);
    @(posedge clock); #1;
    preset_L = 1'b1;
    model_reset();

    // both ports streaming reads
    for (int k = 0; k < 14; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p]) set_req(p, 0, AW'($urandom_range(4095)), '0);
      step();
    end
    idle(4);

    // write then read the same address from the other port
    set_req(0, 1, 12'h123, 32'hDEADBEEF);
    step();
    set_req(1, 0, 12'h123, '0);
    step();
    idle(4);

    // port 1 alone, top of address space
    for (int k = 0; k < 5; k++) begin
      set_req(1, 0, AW'(12'hFFF - k), '0);
      step();
    end
    idle(4);

    // random mixed traffic with address reuse
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p] && $urandom_range(9) < 7)
          set_req(p, 1'($urandom_range(1)),
                  ($urandom_range(15) == 0) ? AW'(12'hFFF)
                                            : AW'($urandom_range(15)),
                  $urandom);
      step();
    end
    pv[0] = 0;
    pv[1] = 0;
    idle(4);

    // reset during the access cycle of a read
    set_req(0, 0, 12'h005, '0);
    step();
    #1 preset_L = 1'b0;
    #1;
    chk("mid_rst_mem_enable", 64'(mem_enable), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    model_reset();
    set_req(0, 0, 12'h006, '0);
    set_req(1, 0, 12'h007, '0);
    @(posedge clock); #1;
    step();
    preset_L = 1'b1;
    step();
    idle(5);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
